// File: rtl/axi_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_pkg
//  Description : Shared burst/response codes, engine state encoding and a
//                ceil-log2 helper for the AXI4 read-only burst memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int              ST_W     = 1;
    localparam logic [ST_W-1:0] ST_IDLE  = 1'b0;
    localparam logic [ST_W-1:0] ST_BURST = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_rd_mem_ar_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axi_ar_fifo
//  Description : Synchronous FIFO holding accepted read-address requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_ar_fifo
    import axi_mem_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int                 c_PTR_W      = clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL_COUNT = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_FULL_COUNT);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_burst_rd_mem.sv
`default_nettype none
// ============================================================================
//  Module      : axi_burst_rd_mem
//  Description : AXI4 read-only slave memory serving FIXED/INCR/WRAP bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_rd_mem
    import axi_mem_pkg::*;
#(
    parameter int    DATA_W        = 32,
    parameter int    ADDR_W        = 32,
    parameter int    DEPTH         = 1024,
    parameter int    ID_W          = 4,
    parameter int    AR_FIFO_DEPTH = 2,
    parameter string INIT_FILE     = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    input  logic [ADDR_W-1:0] S_AXI_ARADDR,
    input  logic [ID_W-1:0]   S_AXI_ARID,
    input  logic [7:0]        S_AXI_ARLEN,
    input  logic [1:0]        S_AXI_ARBURST,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY,
    output logic [DATA_W-1:0] S_AXI_RDATA,
    output logic [ID_W-1:0]   S_AXI_RID,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RLAST
);

    localparam int c_SHIFT = clog2(DATA_W / 8);
    localparam int c_WA_W  = ADDR_W - c_SHIFT;
    localparam int c_IDX_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int c_AR_W  = ADDR_W + ID_W + 10;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // AR queue
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_pop;
    logic [c_AR_W-1:0] w_fifo_data;
    logic [ADDR_W-1:0] w_ar_addr;
    logic [ID_W-1:0]   w_ar_id;
    logic [7:0]        w_ar_len;
    logic [1:0]        w_ar_burst;

    assign S_AXI_ARREADY = !rst && !w_fifo_full;

    axi_ar_fifo #(
        .WIDTH (c_AR_W),
        .DEPTH (AR_FIFO_DEPTH)
    ) u_ar_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (S_AXI_ARVALID && S_AXI_ARREADY),
        .i_data  ({S_AXI_ARADDR, S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARBURST}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign {w_ar_addr, w_ar_id, w_ar_len, w_ar_burst} = w_fifo_data;

    // Illegal bursts degrade to INCR with every beat flagged
    logic              w_wrap_len_ok;
    logic              w_dec_err;
    logic [1:0]        w_dec_burst;
    logic [c_WA_W-1:0] w_dec_addr;

    assign w_wrap_len_ok = (w_ar_len == 8'd1) || (w_ar_len == 8'd3) ||
                           (w_ar_len == 8'd7) || (w_ar_len == 8'd15);
    assign w_dec_err     = (w_ar_burst == BURST_RSVD) ||
                           ((w_ar_burst == BURST_WRAP) && !w_wrap_len_ok);
    assign w_dec_burst   = w_dec_err ? BURST_INCR : w_ar_burst;
    assign w_dec_addr    = c_WA_W'(w_ar_addr >> c_SHIFT);

    // Burst context registers
    logic [ST_W-1:0]   r_state;
    logic [c_WA_W-1:0] r_addr;
    logic [7:0]        r_idx;
    logic [7:0]        r_len;
    logic [1:0]        r_burst;
    logic              r_err;
    logic [ID_W-1:0]   r_id;

    // Output beat registers
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic [ID_W-1:0]   r_rid;
    logic [1:0]        r_rresp;
    logic              r_rlast;

    // The next beat comes from the active burst, or beat 0 of the queue head
    logic              w_in_burst;
    logic              w_load;
    logic              w_have_beat;
    logic [c_WA_W-1:0] w_src_addr;
    logic [7:0]        w_src_idx;
    logic [7:0]        w_src_len;
    logic [1:0]        w_src_burst;
    logic              w_src_err;
    logic [ID_W-1:0]   w_src_id;
    logic              w_src_last;
    logic [c_WA_W-1:0] w_wrap_mask;
    logic [c_WA_W-1:0] w_addr_inc;
    logic [c_WA_W-1:0] w_next_addr;
    logic              w_in_range;
    logic [c_IDX_W-1:0] w_mem_idx;

    assign w_in_burst  = (r_state == ST_BURST);
    assign w_load      = !r_rvalid || S_AXI_RREADY;
    assign w_have_beat = w_in_burst || !w_fifo_empty;
    assign w_pop       = w_load && !w_in_burst && !w_fifo_empty;

    assign w_src_addr  = w_in_burst ? r_addr  : w_dec_addr;
    assign w_src_idx   = w_in_burst ? r_idx   : 8'd0;
    assign w_src_len   = w_in_burst ? r_len   : w_ar_len;
    assign w_src_burst = w_in_burst ? r_burst : w_dec_burst;
    assign w_src_err   = w_in_burst ? r_err   : w_dec_err;
    assign w_src_id    = w_in_burst ? r_id    : w_ar_id;
    assign w_src_last  = (w_src_idx == w_src_len);

    assign w_wrap_mask = c_WA_W'(w_src_len[3:0]);
    assign w_addr_inc  = w_src_addr + c_WA_W'(1);
    assign w_in_range  = (64'(w_src_addr) < 64'(DEPTH));
    assign w_mem_idx   = c_IDX_W'(w_src_addr);

    always_comb begin
        w_next_addr = w_addr_inc;
        case (w_src_burst)
            BURST_FIXED: w_next_addr = w_src_addr;
            BURST_WRAP:  w_next_addr = (w_src_addr & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask);
            default:     w_next_addr = w_addr_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_idx    <= '0;
            r_len    <= '0;
            r_burst  <= BURST_INCR;
            r_err    <= 1'b0;
            r_id     <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rid    <= '0;
            r_rresp  <= RESP_OKAY;
            r_rlast  <= 1'b0;
        end else if (w_load) begin
            if (w_have_beat) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_in_range ? r_mem[w_mem_idx] : '0;
                r_rid    <= w_src_id;
                r_rresp  <= (w_src_err || !w_in_range) ? RESP_SLVERR : RESP_OKAY;
                r_rlast  <= w_src_last;
                r_addr   <= w_next_addr;
                r_idx    <= w_src_idx + 8'd1;
                r_len    <= w_src_len;
                r_burst  <= w_src_burst;
                r_err    <= w_src_err;
                r_id     <= w_src_id;
                // Back to IDLE once the last beat is loaded so the queue head
                // can follow immediately on the RLAST handshake.
                r_state  <= w_src_last ? ST_IDLE : ST_BURST;
            end else begin
                r_rvalid <= 1'b0;
                r_rlast  <= 1'b0;
            end
        end
    end

    assign S_AXI_RVALID = r_rvalid;
    assign S_AXI_RDATA  = r_rdata;
    assign S_AXI_RID    = r_rid;
    assign S_AXI_RRESP  = r_rresp;
    assign S_AXI_RLAST  = r_rlast;

endmodule
`default_nettype wire
